// File: rtl/ram_dp_clr.sv
// Dual-port block RAM (A read/write, B read-only) with a clear sweep, registered valids and optional output stage.
// Optional macro RAM_BYPASS_EN: forward the port A write data to port B when both hit one address in the same cycle.
module ram_dp_clr #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 12,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter int                OUT_REG        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              a_wr;
  logic              a_rd;
  logic              b_rd;
  logic [DATA_W-1:0] b_word;
  logic [DATA_W-1:0] s1_a_dat;
  logic [DATA_W-1:0] s1_b_dat;
  logic              s1_a_vld;
  logic              s1_b_vld;

  assign busy    = (state == ST_CLEAR);
  assign cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign a_wr    = !busy && a_en && a_we;
  assign a_rd    = !busy && a_en && !a_we;
  assign b_rd    = !busy && b_en;

  // The extra counter bit flags completion once the last address has been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (cnt_nxt[ADDR_W]) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end else if (clr_start) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt[ADDR_W-1:0]] <= CLEAR_VALUE;
    end else if (a_wr) begin
      mem[a_addr] <= a_wdata;
    end
  end

`ifdef RAM_BYPASS_EN
  assign b_word = (a_wr && (a_addr == b_addr)) ? a_wdata : mem[b_addr];
`else
  assign b_word = mem[b_addr];
`endif

  // Read data registers only load on a served request, so they hold between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_dat <= '0;
      s1_b_dat <= '0;
      s1_a_vld <= 1'b0;
      s1_b_vld <= 1'b0;
    end else begin
      if (a_rd) s1_a_dat <= mem[a_addr];
      if (b_rd) s1_b_dat <= b_word;
      s1_a_vld <= a_rd;
      s1_b_vld <= b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_a_dat;
      logic [DATA_W-1:0] s2_b_dat;
      logic              s2_a_vld;
      logic              s2_b_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_a_dat <= '0;
          s2_b_dat <= '0;
          s2_a_vld <= 1'b0;
          s2_b_vld <= 1'b0;
        end else begin
          if (s1_a_vld) s2_a_dat <= s1_a_dat;
          if (s1_b_vld) s2_b_dat <= s1_b_dat;
          s2_a_vld <= s1_a_vld;
          s2_b_vld <= s1_b_vld;
        end
      end

      assign a_rdata  = s2_a_dat;
      assign b_rdata  = s2_b_dat;
      assign a_rvalid = s2_a_vld;
      assign b_rvalid = s2_b_vld;
    end else begin : g_noreg
      assign a_rdata  = s1_a_dat;
      assign b_rdata  = s1_b_dat;
      assign a_rvalid = s1_a_vld;
      assign b_rvalid = s1_b_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances (latency 1 and latency 2) on shared inputs, checked every cycle
// against a word-array model plus directed literal expectations.
module tb_ram_dp_clr;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic        clr_start;
  logic        a_en;
  logic        a_we;
  logic [11:0] a_addr;
  logic [15:0] a_wdata;
  logic        b_en;
  logic [11:0] b_addr;

  logic        busy0, busy1;
  logic [15:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;
  logic        a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1;

  int n_vec = 0;
  int n_err = 0;

  ram_dp_clr #(.OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0)
  );

  ram_dp_clr #(.OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: word array, remaining sweep cycles, and per-edge read results aged through a 2-deep history.
  logic [15:0] mm [0:DEPTH-1];
  int          left;
  logic        h_av [0:1];
  logic        h_bv [0:1];
  logic [15:0] h_ad [0:1];
  logic [15:0] h_bd [0:1];
  logic [15:0] hold_a [0:1];
  logic [15:0] hold_b [0:1];
  logic        nav, nbv;
  logic [15:0] nad, nbd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0000;
      for (int l = 0; l < 2; l++) begin
        h_av[l] = 1'b0; h_bv[l] = 1'b0; h_ad[l] = '0; h_bd[l] = '0;
        hold_a[l] = '0; hold_b[l] = '0;
      end
    end else begin
      nav = 1'b0; nbv = 1'b0; nad = '0; nbd = '0;
      if (left == 0) begin
        if (b_en) begin
          nbv = 1'b1;
          nbd = mm[b_addr];
`ifdef RAM_BYPASS_EN
          if (a_en && a_we && a_addr == b_addr) nbd = a_wdata;
`endif
        end
        if (a_en && !a_we) begin
          nav = 1'b1;
          nad = mm[a_addr];
        end
        if (a_en && a_we) mm[a_addr] = a_wdata;
        if (clr_start) begin
          left = DEPTH;
          for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0000;
        end
      end else begin
        left = left - 1;
      end
      h_av[1] = h_av[0]; h_ad[1] = h_ad[0]; h_bv[1] = h_bv[0]; h_bd[1] = h_bd[0];
      h_av[0] = nav;     h_ad[0] = nad;     h_bv[0] = nbv;     h_bd[0] = nbd;
      for (int l = 0; l < 2; l++) begin
        if (h_av[l]) hold_a[l] = h_ad[l];
        if (h_bv[l]) hold_b[l] = h_bd[l];
      end
    end
  end

  always @(negedge clk) begin
    chk("d0_busy",     {31'd0, busy0},     {31'd0, left != 0});
    chk("d1_busy",     {31'd0, busy1},     {31'd0, left != 0});
    chk("d0_a_rvalid", {31'd0, a_rvalid0}, {31'd0, h_av[0]});
    chk("d0_b_rvalid", {31'd0, b_rvalid0}, {31'd0, h_bv[0]});
    chk("d0_a_rdata",  {16'd0, a_rdata0},  {16'd0, hold_a[0]});
    chk("d0_b_rdata",  {16'd0, b_rdata0},  {16'd0, hold_b[0]});
    chk("d1_a_rvalid", {31'd0, a_rvalid1}, {31'd0, h_av[1]});
    chk("d1_b_rvalid", {31'd0, b_rvalid1}, {31'd0, h_bv[1]});
    chk("d1_a_rdata",  {16'd0, a_rdata1},  {16'd0, hold_a[1]});
    chk("d1_b_rdata",  {16'd0, b_rdata1},  {16'd0, hold_b[1]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_start = 1'b0; a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
  endtask

  task automatic wr_a(input logic [11:0] ad, input logic [15:0] d);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d;
  endtask

  task automatic rd_a(input logic [11:0] ad);
    a_en = 1'b1; a_we = 1'b0; a_addr = ad;
  endtask

  task automatic rd_b(input logic [11:0] ad);
    b_en = 1'b1; b_addr = ad;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy0 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n;

  initial begin
    rst_n = 1'b0; a_addr = '0; a_wdata = '0; b_addr = '0;
    idle();
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy0}, 32'd1);
    chk("rst_a_rdata", {16'd0, a_rdata0}, 32'h0);
    chk("rst_b_rvalid", {31'd0, b_rvalid1}, 32'd0);

    // Power-up sweep length, then read of the last address
    rst_n = 1'b1;
    wait_busy(n);
    chk("sweep_len_reset", n, 32'd4096);
    rd_b(12'hFFF); tick(); idle();
    chk("t1_b_rvalid", {31'd0, b_rvalid0}, 32'd1);
    chk("t1_b_rdata", {16'd0, b_rdata0}, 32'h0000);
    tick();
    chk("t1_b_rvalid_drop", {31'd0, b_rvalid0}, 32'd0);
    chk("t1_d1_b_rvalid", {31'd0, b_rvalid1}, 32'd1);

    // Write then read back
    wr_a(12'h005, 16'hBEEF); tick();
    chk("t2_wr_rvalid", {31'd0, a_rvalid0}, 32'd0);
    rd_a(12'h005); tick(); idle();
    chk("t2_a_rdata", {16'd0, a_rdata0}, 32'hBEEF);
    chk("t2_a_rvalid", {31'd0, a_rvalid0}, 32'd1);
    tick();
    chk("t2_a_rvalid_drop", {31'd0, a_rvalid0}, 32'd0);

    // Both ports read the same word
    rd_a(12'h005); rd_b(12'h005); tick(); idle();
    chk("same_a", {16'd0, a_rdata0}, 32'hBEEF);
    chk("same_b", {16'd0, b_rdata0}, 32'hBEEF);

    // A write leaves a_rdata holding
    wr_a(12'h007, 16'h1234); tick();
    rd_a(12'h007); tick();
    chk("t3_a_rdata", {16'd0, a_rdata0}, 32'h1234);
    wr_a(12'h006, 16'h5555); tick(); idle();
    chk("t3_hold", {16'd0, a_rdata0}, 32'h1234);
    chk("t3_rvalid", {31'd0, a_rvalid0}, 32'd0);

    // Write/read collision
    wr_a(12'h010, 16'h1111); tick();
    wr_a(12'h010, 16'h2222); rd_b(12'h010); tick(); idle();
`ifdef RAM_BYPASS_EN
    chk("t4_collide", {16'd0, b_rdata0}, 32'h2222);
`else
    chk("t4_collide", {16'd0, b_rdata0}, 32'h1111);
`endif
    rd_b(12'h010); tick(); idle();
    chk("t4_after", {16'd0, b_rdata0}, 32'h2222);

    // Back-to-back reads through the registered-output instance
    wr_a(12'h001, 16'h00A1); tick();
    wr_a(12'h002, 16'h00A2); tick();
    wr_a(12'h003, 16'h00A3); tick();
    rd_a(12'h001); tick();
    chk("t6_d1_vld0", {31'd0, a_rvalid1}, 32'd0);
    chk("t6_d0_dat1", {16'd0, a_rdata0}, 32'h00A1);
    rd_a(12'h002); tick();
    chk("t6_d1_vld1", {31'd0, a_rvalid1}, 32'd1);
    chk("t6_d1_dat1", {16'd0, a_rdata1}, 32'h00A1);
    rd_a(12'h003); tick(); idle();
    chk("t6_d1_vld2", {31'd0, a_rvalid1}, 32'd1);
    chk("t6_d1_dat2", {16'd0, a_rdata1}, 32'h00A2);
    tick();
    chk("t6_d1_vld3", {31'd0, a_rvalid1}, 32'd1);
    chk("t6_d1_dat3", {16'd0, a_rdata1}, 32'h00A3);
    tick();
    chk("t6_d1_vld4", {31'd0, a_rvalid1}, 32'd0);
    chk("t6_d1_hold", {16'd0, a_rdata1}, 32'h00A3);

    // Requested sweep; same-cycle requests still served
    wr_a(12'h020, 16'h7777); rd_b(12'h005); clr_start = 1'b1; tick(); idle();
    chk("clr_b_served", {16'd0, b_rdata0}, 32'hBEEF);
    chk("clr_busy", {31'd0, busy0}, 32'd1);
    wait_busy(n);
    chk("sweep_len_req", n, 32'd4096);
    rd_a(12'h020); rd_b(12'h005); tick(); idle();
    chk("clr_a_zero", {16'd0, a_rdata0}, 32'h0000);
    chk("clr_b_zero", {16'd0, b_rdata0}, 32'h0000);

    // Reset mid-sweep restarts it; write during busy is dropped
    clr_start = 1'b1; tick(); idle();
    repeat (50) tick();
    wr_a(12'h030, 16'h9999); rd_b(12'h030); tick(); idle();
    repeat (49) tick();
    rst_n = 1'b0; tick();
    chk("t5_rst_busy", {31'd0, busy0}, 32'd1);
    rst_n = 1'b1;
    wait_busy(n);
    chk("sweep_len_restart", n, 32'd4096);
    rd_a(12'h030); tick(); idle();
    chk("t5_write_absent", {16'd0, a_rdata0}, 32'h0000);
    chk("t5_rvalid", {31'd0, a_rvalid0}, 32'd1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
